vga_pattern_ctrl: RTL and testbench

Sequencing controller for the VGA test-pattern path. It takes debounced switch levels, UART command bytes and a start-of-frame strobe. It decides which pattern and blanking state the pattern generator shows, and commits every change only at a frame boundary so no frame is ever torn. It sits between the switch debouncers / UART receiver and the pattern generator, and returns a one-byte acknowledgement to the UART transmitter.

---
 rtl/vga_pkg.sv | 27 ++
 rtl/rise_detect.sv | 34 +++
 rtl/vga_pattern_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_vga_pattern_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the VGA test-pattern control path:
//   NUM_PATTERNS / PAT_W  - pattern count and pattern index width
//   CMD_*                 - ASCII command bytes accepted on the UART
//   ACK_BAD               - acknowledgement returned for an unknown byte
//   tx_state_t            - acknowledgement FSM state encoding
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int NUM_PATTERNS = 8;
    localparam int PAT_W        = 3;

    localparam logic [7:0] CMD_DIGIT0 = 8'h30;  // '0'; '0'..'7' select directly
    localparam logic [7:0] CMD_AUTO   = 8'h61;  // 'a'
    localparam logic [7:0] CMD_BLANK  = 8'h62;  // 'b'
    localparam logic [7:0] CMD_NEXT   = 8'h6E;  // 'n'
    localparam logic [7:0] CMD_PREV   = 8'h70;  // 'p'
    localparam logic [7:0] ACK_BAD    = 8'h3F;  // '?'

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_WAIT = 2'd1,
        TX_HOLD = 2'd2
    } tx_state_t;

endpackage

// File: rtl/rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
// One-bit rising-edge detector. The previous level is registered; rise is high
// for the single cycle in which d is high and was low on the previous edge.
// The history register resets to 0, so a level already high when reset
// releases yields exactly one event.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   d    - level input (already debounced / synchronous)
//   rise - one-cycle event on a 0->1 transition
// -----------------------------------------------------------------------------
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic prev;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= d;
        end
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/vga_pattern_ctrl.sv
// -----------------------------------------------------------------------------
// vga_pattern_ctrl
// Chooses the pattern index and blanking state shown by the pattern generator.
// Switch and UART requests update shadow registers (next_pattern, next_blank)
// and raise a pending flag; the shadows are committed only on i_Frame_Start so
// a frame is never torn. Auto mode advances the pattern every AUTO_FRAMES
// frames. Each UART command is acknowledged with one byte to the transmitter.
// Ports:
//   CLK, RST          - clock, asynchronous active-high reset
//   i_SW1..i_SW4      - debounced switches: next, previous, toggle auto, toggle blank
//   i_Rx_DV/i_Rx_Byte - received command strobe and byte
//   i_Frame_Start     - one-cycle strobe at pixel (0,0)
//   i_Tx_Active       - UART transmitter busy
//   o_Pattern/o_Blank - active pattern index and force-black
//   o_Auto            - auto-cycle enabled
//   o_Pending         - a change is waiting for the next frame start
//   o_Tx_DV/o_Tx_Byte - acknowledgement strobe and byte
// -----------------------------------------------------------------------------
module vga_pattern_ctrl
    import vga_pkg::*;
#(
    parameter int NUM_PATTERNS = vga_pkg::NUM_PATTERNS,
    parameter int AUTO_FRAMES  = 60,
    parameter int FRAME_CNT_W  = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_SW1,
    input  logic             i_SW2,
    input  logic             i_SW3,
    input  logic             i_SW4,
    input  logic             i_Rx_DV,
    input  logic [7:0]       i_Rx_Byte,
    input  logic             i_Frame_Start,
    input  logic             i_Tx_Active,
    output logic [PAT_W-1:0] o_Pattern,
    output logic             o_Blank,
    output logic             o_Auto,
    output logic             o_Pending,
    output logic             o_Tx_DV,
    output logic [7:0]       o_Tx_Byte
);

    typedef logic [PAT_W-1:0] pat_t;

    function automatic pat_t pat_inc(input pat_t p);
        return (int'(p) == NUM_PATTERNS - 1) ? '0 : pat_t'(p + 1'b1);
    endfunction

    function automatic pat_t pat_dec(input pat_t p);
        return (p == '0) ? pat_t'(NUM_PATTERNS - 1) : pat_t'(p - 1'b1);
    endfunction

    // ---------------------------------------------------------------- edges
    logic sw1_rise, sw2_rise, sw3_rise, sw4_rise;

    rise_detect u_rise_sw1 (.clk(CLK), .rst(RST), .d(i_SW1), .rise(sw1_rise));
    rise_detect u_rise_sw2 (.clk(CLK), .rst(RST), .d(i_SW2), .rise(sw2_rise));
    rise_detect u_rise_sw3 (.clk(CLK), .rst(RST), .d(i_SW3), .rise(sw3_rise));
    rise_detect u_rise_sw4 (.clk(CLK), .rst(RST), .d(i_SW4), .rise(sw4_rise));

    // --------------------------------------------------------------- decode
    logic is_digit, is_auto, is_blank, is_next, is_prev, cmd_known;
    logic req_set, req_next, req_prev, req_auto, req_blank;

    always_comb begin
        is_digit  = (int'(i_Rx_Byte) >= int'(CMD_DIGIT0)) &&
                    (int'(i_Rx_Byte) <  int'(CMD_DIGIT0) + NUM_PATTERNS);
        is_auto   = (i_Rx_Byte == CMD_AUTO);
        is_blank  = (i_Rx_Byte == CMD_BLANK);
        is_next   = (i_Rx_Byte == CMD_NEXT);
        is_prev   = (i_Rx_Byte == CMD_PREV);
        cmd_known = is_digit | is_auto | is_blank | is_next | is_prev;

        // A UART strobe masks every switch event of the same cycle, even for
        // an unknown byte. SW1+SW2 together cancel out.
        req_set   = i_Rx_DV & is_digit;
        req_next  = i_Rx_DV ? is_next  : (sw1_rise & ~sw2_rise);
        req_prev  = i_Rx_DV ? is_prev  : (sw2_rise & ~sw1_rise);
        req_auto  = i_Rx_DV ? is_auto  : sw3_rise;
        req_blank = i_Rx_DV ? is_blank : sw4_rise;
    end

    // ------------------------------------------------ shadow / commit logic
    pat_t                   pattern_q, pattern_d, next_pat_q, next_pat_d;
    logic                   blank_q, blank_d, next_blank_q, next_blank_d;
    logic                   pending_q, pending_d, auto_q, auto_d;
    logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        pattern_d    = pattern_q;
        blank_d      = blank_q;
        next_pat_d   = next_pat_q;
        next_blank_d = next_blank_q;
        pending_d    = pending_q;
        auto_d       = auto_q;
        fcnt_d       = fcnt_q;

        // Frame start acts on state from before this cycle; a request that
        // arrives now lands in the shadows afterwards and waits a frame.
        if (i_Frame_Start) begin
            if (pending_q) begin
                pattern_d = next_pat_q;
                blank_d   = next_blank_q;
                pending_d = 1'b0;
                fcnt_d    = '0;
            end else if (auto_q) begin
                if (fcnt_q == FRAME_CNT_W'(AUTO_FRAMES - 1)) begin
                    next_pat_d = pat_inc(next_pat_q);
                    pattern_d  = pat_inc(next_pat_q);
                    fcnt_d     = '0;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
        end

        if (req_set)   next_pat_d   = pat_t'(i_Rx_Byte[PAT_W-1:0]);
        if (req_next)  next_pat_d   = pat_inc(next_pat_d);
        if (req_prev)  next_pat_d   = pat_dec(next_pat_d);
        if (req_blank) next_blank_d = ~next_blank_d;

        if (req_set | req_next | req_prev | req_blank) begin
            pending_d = 1'b1;
            fcnt_d    = '0;
        end

        if (req_auto) begin
            auto_d = ~auto_q;
            fcnt_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pattern_q    <= '0;
            blank_q      <= 1'b0;
            next_pat_q   <= '0;
            next_blank_q <= 1'b0;
            pending_q    <= 1'b0;
            auto_q       <= 1'b0;
            fcnt_q       <= '0;
        end else begin
            pattern_q    <= pattern_d;
            blank_q      <= blank_d;
            next_pat_q   <= next_pat_d;
            next_blank_q <= next_blank_d;
            pending_q    <= pending_d;
            auto_q       <= auto_d;
            fcnt_q       <= fcnt_d;
        end
    end

    assign o_Pattern = pattern_q;
    assign o_Blank   = blank_q;
    assign o_Auto    = auto_q;
    assign o_Pending = pending_q;

    // ------------------------------------------------------ acknowledgement
    tx_state_t  tx_state;
    logic       tx_requeue;  // command latched during TX_HOLD
    logic [7:0] ack_byte;

    assign ack_byte = cmd_known ? i_Rx_Byte : ACK_BAD;

    // o_Tx_Byte doubles as the latch: it changes only when a new ack is
    // captured, so it is stable across the o_Tx_DV pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tx_state   <= TX_IDLE;
            tx_requeue <= 1'b0;
            o_Tx_DV    <= 1'b0;
            o_Tx_Byte  <= 8'h00;
        end else begin
            o_Tx_DV <= 1'b0;
            if (i_Rx_DV) begin
                o_Tx_Byte <= ack_byte;
            end
            case (tx_state)
                TX_IDLE: begin
                    if (i_Rx_DV) tx_state <= TX_WAIT;
                end
                TX_WAIT: begin
                    // A fresh command restarts the wait with the newest byte.
                    if (!i_Rx_DV && !i_Tx_Active) begin
                        o_Tx_DV  <= 1'b1;
                        tx_state <= TX_HOLD;
                    end
                end
                TX_HOLD: begin
                    if (i_Tx_Active) begin
                        tx_state   <= (tx_requeue || i_Rx_DV) ? TX_WAIT : TX_IDLE;
                        tx_requeue <= 1'b0;
                    end else if (i_Rx_DV) begin
                        tx_requeue <= 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_pattern_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vga_pattern_ctrl
// Directed bench for vga_pattern_ctrl with AUTO_FRAMES = 3. Inputs change 1 ns
// after the rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_vga_pattern_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       i_SW1, i_SW2, i_SW3, i_SW4;
    logic       i_Rx_DV;
    logic [7:0] i_Rx_Byte;
    logic       i_Frame_Start;
    logic       i_Tx_Active;
    logic [2:0] o_Pattern;
    logic       o_Blank, o_Auto, o_Pending, o_Tx_DV;
    logic [7:0] o_Tx_Byte;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    vga_pattern_ctrl #(
        .NUM_PATTERNS(8),
        .AUTO_FRAMES (3),
        .FRAME_CNT_W (6)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .i_SW1        (i_SW1),
        .i_SW2        (i_SW2),
        .i_SW3        (i_SW3),
        .i_SW4        (i_SW4),
        .i_Rx_DV      (i_Rx_DV),
        .i_Rx_Byte    (i_Rx_Byte),
        .i_Frame_Start(i_Frame_Start),
        .i_Tx_Active  (i_Tx_Active),
        .o_Pattern    (o_Pattern),
        .o_Blank      (o_Blank),
        .o_Auto       (o_Auto),
        .o_Pending    (o_Pending),
        .o_Tx_DV      (o_Tx_DV),
        .o_Tx_Byte    (o_Tx_Byte)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        i_Rx_DV   = 1'b1;
        i_Rx_Byte = b;
        tick();
        i_Rx_DV   = 1'b0;
        i_Rx_Byte = 8'h00;
    endtask

    // Lets a queued ack go out, then shows the transmitter busy so the FSM
    // returns to idle.
    task automatic ack_drain();
        tick();
        i_Tx_Active = 1'b1;
        tick();
        i_Tx_Active = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] b);
        rx_pulse(b);
        ack_drain();
    endtask

    task automatic frame();
        i_Frame_Start = 1'b1;
        tick();
        i_Frame_Start = 1'b0;
    endtask

    task automatic press(input int sw);
        case (sw)
            1: i_SW1 = 1'b1;
            2: i_SW2 = 1'b1;
            3: i_SW3 = 1'b1;
            default: i_SW4 = 1'b1;
        endcase
        tick();
        i_SW1 = 1'b0; i_SW2 = 1'b0; i_SW3 = 1'b0; i_SW4 = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dv_count;

        RST = 1'b1;
        i_SW1 = 1'b0; i_SW2 = 1'b0; i_SW3 = 1'b0; i_SW4 = 1'b0;
        i_Rx_DV = 1'b0; i_Rx_Byte = 8'h00;
        i_Frame_Start = 1'b0; i_Tx_Active = 1'b0;
        tick();
        tick();
        check("rst_pattern", 8'(o_Pattern), 8'd0);
        check("rst_blank",   8'(o_Blank),   8'd0);
        check("rst_auto",    8'(o_Auto),    8'd0);
        check("rst_pending", 8'(o_Pending), 8'd0);
        check("rst_tx_dv",   8'(o_Tx_DV),   8'd0);
        check("rst_tx_byte", o_Tx_Byte,     8'h00);
        RST = 1'b0;
        tick();

        // '5': pending after 1 cycle, ack 2 cycles after strobe, commit at frame
        rx_pulse(8'h35);
        check("t1_pending",      8'(o_Pending), 8'd1);
        check("t1_pat_hold",     8'(o_Pattern), 8'd0);
        check("t1_dv_early",     8'(o_Tx_DV),   8'd0);
        tick();
        check("t1_dv",           8'(o_Tx_DV),   8'd1);
        check("t1_byte",         o_Tx_Byte,     8'h35);
        tick();
        check("t1_dv_one_cycle", 8'(o_Tx_DV),   8'd0);
        i_Tx_Active = 1'b1;
        tick();
        i_Tx_Active = 1'b0;
        tick();
        check("t1_pat_still",    8'(o_Pattern), 8'd0);
        frame();
        check("t1_pat_commit",   8'(o_Pattern), 8'd5);
        check("t1_pending_clr",  8'(o_Pending), 8'd0);

        // Accumulating next with wrap 7 -> 2; previous wrap 0 -> 7
        cmd(8'h37);
        frame();
        check("t2_pat7", 8'(o_Pattern), 8'd7);
        press(1);
        press(1);
        press(1);
        check("t2_pat_held", 8'(o_Pattern), 8'd7);
        frame();
        check("t2_next_x3", 8'(o_Pattern), 8'd2);
        cmd(8'h30);
        frame();
        check("t2_pat0", 8'(o_Pattern), 8'd0);
        press(2);
        frame();
        check("t2_prev_wrap", 8'(o_Pattern), 8'd7);

        // Auto mode, 3 frames per pattern
        cmd(8'h30);
        frame();
        cmd(8'h61);
        check("t3_auto_on", 8'(o_Auto), 8'd1);
        frame();
        frame();
        check("t3_f2", 8'(o_Pattern), 8'd0);
        frame();
        check("t3_f3", 8'(o_Pattern), 8'd1);
        frame();
        frame();
        check("t3_f5", 8'(o_Pattern), 8'd1);
        frame();
        check("t3_f6", 8'(o_Pattern), 8'd2);
        frame();
        press(1);
        check("t3_sw1_pending", 8'(o_Pending), 8'd1);
        frame();
        check("t3_sw1_commit", 8'(o_Pattern), 8'd3);
        frame();
        frame();
        check("t3_restart_hold", 8'(o_Pattern), 8'd3);
        frame();
        check("t3_restart_step", 8'(o_Pattern), 8'd4);
        cmd(8'h61);
        check("t3_auto_off", 8'(o_Auto), 8'd0);

        // UART beats a same-cycle SW1 edge
        i_Rx_DV = 1'b1; i_Rx_Byte = 8'h33; i_SW1 = 1'b1;
        tick();
        i_Rx_DV = 1'b0; i_Rx_Byte = 8'h00; i_SW1 = 1'b0;
        ack_drain();
        frame();
        check("t4_uart_wins", 8'(o_Pattern), 8'd3);

        // Request coincident with frame start waits one frame
        i_Frame_Start = 1'b1; i_Rx_DV = 1'b1; i_Rx_Byte = 8'h36;
        tick();
        i_Frame_Start = 1'b0; i_Rx_DV = 1'b0; i_Rx_Byte = 8'h00;
        check("t4_coinc_hold",    8'(o_Pattern), 8'd3);
        check("t4_coinc_pending", 8'(o_Pending), 8'd1);
        ack_drain();
        frame();
        check("t4_coinc_apply",   8'(o_Pattern), 8'd6);

        // Unknown byte then 'b' while busy: one ack with the newest byte
        i_Tx_Active = 1'b1;
        rx_pulse(8'h7A);
        check("t5_bad_byte",   o_Tx_Byte,     8'h3F);
        check("t5_bad_nopend", 8'(o_Pending), 8'd0);
        rx_pulse(8'h62);
        check("t5_b_byte",     o_Tx_Byte,     8'h62);
        tick();
        check("t5_busy_nodv",  8'(o_Tx_DV),   8'd0);
        i_Tx_Active = 1'b0;
        tick();
        check("t5_dv",         8'(o_Tx_DV),   8'd1);
        check("t5_dv_byte",    o_Tx_Byte,     8'h62);
        tick();
        check("t5_dv_single",  8'(o_Tx_DV),   8'd0);
        i_Tx_Active = 1'b1;
        tick();
        i_Tx_Active = 1'b0;
        check("t5_blank_held", 8'(o_Blank),   8'd0);
        frame();
        check("t5_blank",      8'(o_Blank),   8'd1);

        // Reset while pending and ack waiting
        i_Tx_Active = 1'b1;
        rx_pulse(8'h31);
        check("t6_pending", 8'(o_Pending), 8'd1);
        #2;
        RST = 1'b1;
        #1;
        check("t6_async_pattern", 8'(o_Pattern), 8'd0);
        check("t6_async_blank",   8'(o_Blank),   8'd0);
        check("t6_async_pending", 8'(o_Pending), 8'd0);
        check("t6_async_byte",    o_Tx_Byte,     8'h00);
        check("t6_async_auto",    8'(o_Auto),    8'd0);
        tick();
        RST = 1'b0;
        i_Tx_Active = 1'b0;
        dv_count = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (o_Tx_DV) dv_count++;
        end
        check("t6_no_dv", 8'(dv_count), 8'd0);
        frame();
        check("t6_pat_after", 8'(o_Pattern), 8'd0);
        check("t6_pend_after", 8'(o_Pending), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
